// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM states for the sequential ALU.
// Pure definitions; no latency or flow-control behaviour of its own.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_AND = 4'b1100;
    localparam logic [3:0] OP_OR  = 4'b1101;
    localparam logic [3:0] OP_XOR = 4'b1110;
    localparam logic [3:0] OP_SHL = 4'b1111;
    localparam logic [3:0] OP_NOT = 4'b0010;

    localparam int FLG_C = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_V = 0;

    typedef enum logic {INACTIVO, CALCULO} estado_t;
endpackage

// File: rtl/alu_iterativa.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one step per clock.
// Finishes after WIDTH steps; o_Bajo/o_Alto show the post-step value so the caller can register it on o_Hecho.
module alu_iterativa
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_Inicio,
    input  logic             i_Es_Div,
    input  logic             i_Activo,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             o_Hecho,
    output logic             o_Es_Div,
    output logic             o_Div_Cero,
    output logic [WIDTH-1:0] o_Bajo,
    output logic [WIDTH-1:0] o_Alto
);
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             es_div_q, es_div_d;
    logic [WIDTH:0]   suma, desp, resta;

    // acc holds the high product / partial remainder; sr holds the multiplier / dividend-then-quotient
    always_comb begin
        acc_d    = acc_q;
        sr_d     = sr_q;
        m_d      = m_q;
        cnt_d    = cnt_q;
        es_div_d = es_div_q;
        suma     = {1'b0, acc_q} + {1'b0, m_q};
        desp     = {acc_q, sr_q[WIDTH-1]};
        resta    = desp - {1'b0, m_q};
        if (i_Inicio) begin
            acc_d    = '0;
            sr_d     = i_Es_Div ? i_A : i_B;
            m_d      = i_Es_Div ? i_B : i_A;
            cnt_d    = '0;
            es_div_d = i_Es_Div;
        end else if (i_Activo) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (es_div_q) begin
                if (desp >= {1'b0, m_q}) begin
                    acc_d = resta[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = desp[WIDTH-1:0];
                    sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                end
            end else if (sr_q[0]) begin
                {acc_d, sr_d} = {suma, sr_q[WIDTH-1:1]};
            end else begin
                {acc_d, sr_d} = {1'b0, acc_q, sr_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            acc_q    <= '0;
            sr_q     <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            es_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            sr_q     <= sr_d;
            m_q      <= m_d;
            cnt_q    <= cnt_d;
            es_div_q <= es_div_d;
        end
    end

    assign o_Hecho    = i_Activo && (cnt_q == CNT_W'(WIDTH - 1));
    assign o_Es_Div   = es_div_q;
    assign o_Div_Cero = (m_q == '0);
    assign o_Bajo     = sr_d;
    assign o_Alto     = acc_d;
endmodule

// File: rtl/alu_secuencial.sv
// Registered ALU with valid/ready request handshake; single-cycle ops answer 1 clock after accept, MUL/DIV WIDTH+1.
// o_Listo drops for WIDTH cycles during MUL/DIV; results are a one-cycle o_Valido pulse with no output backpressure.
module alu_secuencial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Valido,
    input  logic [3:0]         i_Control_ALU,
    input  logic [2*WIDTH-1:0] i_Operandos,
    output logic               o_Listo,
    output logic               o_Valido,
    output logic [WIDTH-1:0]   o_Resultado,
    output logic [WIDTH-1:0]   o_Resultado_Alto,
    output logic [2:0]         o_Banderas_Estado
);
    localparam int SH_W = $clog2(WIDTH);

    estado_t          estado_q, estado_d;
    logic [WIDTH-1:0] res_q, res_d, alto_q, alto_d;
    logic [2:0]       flg_q, flg_d;
    logic             vld_q, vld_d;

    logic [WIDTH-1:0] op_a, op_b, alu_res, it_bajo, it_alto;
    logic [WIDTH:0]   alu_tmp;
    logic             alu_c, alu_v, alu_def, inicio, it_hecho, it_es_div, it_div_cero;

    assign op_a = i_Operandos[2*WIDTH-1:WIDTH];
    assign op_b = i_Operandos[WIDTH-1:0];

    // alu_def marks defined single-cycle ops; undefined opcodes report no flags, not even Z
    always_comb begin
        alu_tmp = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_def = 1'b1;
        case (i_Control_ALU)
            OP_ADD: begin
                alu_tmp = {1'b0, op_a} + {1'b0, op_b};
                alu_res = alu_tmp[WIDTH-1:0];
                alu_c   = alu_tmp[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_tmp = {1'b0, op_a} - {1'b0, op_b};
                alu_res = alu_tmp[WIDTH-1:0];
                alu_c   = alu_tmp[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_NOT: alu_res = ~op_a;
            OP_SHL: begin
                alu_tmp = {1'b0, op_a} << op_b[SH_W-1:0];
                alu_res = alu_tmp[WIDTH-1:0];
                alu_c   = alu_tmp[WIDTH];
            end
            default: alu_def = 1'b0;
        endcase
    end

    always_comb begin
        estado_d = estado_q;
        res_d    = res_q;
        alto_d   = alto_q;
        flg_d    = flg_q;
        vld_d    = 1'b0;
        inicio   = 1'b0;
        case (estado_q)
            INACTIVO: begin
                if (i_Valido) begin
                    if ((i_Control_ALU == OP_MUL) || (i_Control_ALU == OP_DIV)) begin
                        inicio   = 1'b1;
                        estado_d = CALCULO;
                    end else begin
                        res_d        = alu_res;
                        alto_d       = '0;
                        flg_d        = '0;
                        flg_d[FLG_C] = alu_c;
                        flg_d[FLG_Z] = alu_def && (alu_res == '0);
                        flg_d[FLG_V] = alu_v;
                        vld_d        = 1'b1;
                    end
                end
            end
            CALCULO: begin
                if (it_hecho) begin
                    estado_d     = INACTIVO;
                    res_d        = it_bajo;
                    alto_d       = it_alto;
                    flg_d        = '0;
                    flg_d[FLG_Z] = (it_bajo == '0);
                    flg_d[FLG_V] = it_es_div ? it_div_cero : (it_alto != '0);
                    vld_d        = 1'b1;
                end
            end
            default: estado_d = INACTIVO;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            estado_q <= INACTIVO;
            res_q    <= '0;
            alto_q   <= '0;
            flg_q    <= '0;
            vld_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            res_q    <= res_d;
            alto_q   <= alto_d;
            flg_q    <= flg_d;
            vld_q    <= vld_d;
        end
    end

    alu_iterativa #(.WIDTH(WIDTH)) u_iterativa (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Inicio   (inicio),
        .i_Es_Div   (i_Control_ALU == OP_DIV),
        .i_Activo   (estado_q == CALCULO),
        .i_A        (op_a),
        .i_B        (op_b),
        .o_Hecho    (it_hecho),
        .o_Es_Div   (it_es_div),
        .o_Div_Cero (it_div_cero),
        .o_Bajo     (it_bajo),
        .o_Alto     (it_alto)
    );

    assign o_Listo           = (estado_q == INACTIVO);
    assign o_Valido          = vld_q;
    assign o_Resultado       = res_q;
    assign o_Resultado_Alto  = alto_q;
    assign o_Banderas_Estado = flg_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial: arithmetic reference model compared every cycle, plus directed literal checks.
module tb_alu_secuencial;
    import alu_pkg::*;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic           i_Clk = 1'b0;
    logic           i_Reset, i_Valido;
    logic [3:0]     i_Control_ALU;
    logic [2*W-1:0] i_Operandos;
    logic           o_Listo, o_Valido;
    logic [W-1:0]   o_Resultado, o_Resultado_Alto;
    logic [2:0]     o_Banderas_Estado;

    int n_vec = 0, n_err = 0;
    bit chk_en = 1'b0;

    always #5 i_Clk = ~i_Clk;

    alu_secuencial #(.WIDTH(W)) dut (
        .i_Clk             (i_Clk),
        .i_Reset           (i_Reset),
        .i_Valido          (i_Valido),
        .i_Control_ALU     (i_Control_ALU),
        .i_Operandos       (i_Operandos),
        .o_Listo           (o_Listo),
        .o_Valido          (o_Valido),
        .o_Resultado       (o_Resultado),
        .o_Resultado_Alto  (o_Resultado_Alto),
        .o_Banderas_Estado (o_Banderas_Estado)
    );

    function automatic logic [31:0] pack(input logic l, input logic v, input logic [W-1:0] h,
                                         input logic [W-1:0] r, input logic [2:0] f);
        return {11'b0, l, v, h, r, f};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(o_Listo, o_Valido, o_Resultado_Alto, o_Resultado, o_Banderas_Estado);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the opcode definitions
    task automatic model_op(input int op, input int a, input int b, output int res, output int hi, output int flg);
        int sa, sb, s, sh, c, v;
        bit known;
        c = 0; v = 0; res = 0; hi = 0; known = 1;
        sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
        case (op)
            8:  begin res = (a + b) & MASK; c = int'((a + b) > MASK); s = sa + sb;
                      v = int'((s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)))); end
            9:  begin res = (a - b) & MASK; c = int'(a < b); s = sa - sb;
                      v = int'((s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)))); end
            10: begin res = (a * b) & MASK; hi = (a * b) >> W; v = int'(hi != 0); end
            11: begin
                    if (b == 0) begin res = MASK; hi = a; v = 1; end
                    else begin res = a / b; hi = a % b; end
                end
            12: res = a & b;
            13: res = a | b;
            14: res = a ^ b;
            15: begin sh = b % W; res = (a << sh) & MASK; c = (sh == 0) ? 0 : ((a >> (W - sh)) & 1); end
            2:  res = (~a) & MASK;
            default: known = 0;
        endcase
        flg = c * 4 + ((known && res == 0) ? 2 : 0) + v;
    endtask

    int m_busy = 0, m_cnt = 0, m_vld = 0, m_res = 0, m_hi = 0, m_flg = 0;
    int p_res = 0, p_hi = 0, p_flg = 0;

    always @(posedge i_Clk) begin
        int r, h, f, op;
        m_vld = 0;
        if (i_Reset) begin
            m_busy = 0; m_res = 0; m_hi = 0; m_flg = 0;
        end else if (m_busy != 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy = 0; m_res = p_res; m_hi = p_hi; m_flg = p_flg; m_vld = 1;
            end
        end else if (i_Valido) begin
            op = int'(i_Control_ALU);
            model_op(op, int'(i_Operandos[2*W-1:W]), int'(i_Operandos[W-1:0]), r, h, f);
            if (op == 10 || op == 11) begin
                m_busy = 1; m_cnt = W; p_res = r; p_hi = h; p_flg = f;
            end else begin
                m_res = r; m_hi = h; m_flg = f; m_vld = 1;
            end
        end
    end

    always @(posedge i_Clk) begin
        #1;
        if (chk_en)
            chk("cycle", dut_vec(),
                pack(m_busy == 0, m_vld != 0, W'(m_hi), W'(m_res), 3'(m_flg)));
    end

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_Valido = 1'b1; i_Control_ALU = op; i_Operandos = {a, b};
    endtask

    task automatic iter_case(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                             input logic [2:0] f);
        int lat, low;
        lat = 1; low = 0;
        drive(op, a, b);
        @(negedge i_Clk);
        i_Valido = 1'b0;
        while (!o_Valido && lat < 40) begin
            if (!o_Listo) low++;
            @(negedge i_Clk);
            lat++;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
        chk({nm, "_listo_low"}, 32'(low), 32'(W));
        chk({nm, "_out"}, dut_vec(), pack(1'b1, 1'b1, hi, lo, f));
        chk({nm, "_model"}, pack(1'b1, 1'b1, W'(m_hi), W'(m_res), 3'(m_flg)), pack(1'b1, 1'b1, hi, lo, f));
    endtask

    initial begin
        int pulses;
        logic [W-1:0] seen;
        i_Reset = 1'b1; i_Valido = 1'b0; i_Control_ALU = '0; i_Operandos = '0;
        repeat (2) @(negedge i_Clk);
        i_Reset = 1'b0;
        chk("reset_state", dut_vec(), pack(1'b1, 1'b0, 8'h00, 8'h00, 3'b000));
        chk_en = 1'b1;

        drive(OP_ADD, 8'h7F, 8'h01);
        @(negedge i_Clk); i_Valido = 1'b0;
        chk("add_out", dut_vec(), pack(1'b1, 1'b1, 8'h00, 8'h80, 3'b001));
        chk("add_model", 32'(m_res * 8 + m_flg), 32'(8'h80 * 8 + 1));

        drive(OP_SUB, 8'hEE, 8'hF7);
        @(negedge i_Clk);
        chk("sub_out", dut_vec(), pack(1'b1, 1'b1, 8'h00, 8'hF7, 3'b100));
        drive(OP_XOR, 8'h55, 8'h55);
        @(negedge i_Clk); i_Valido = 1'b0;
        chk("xor_b2b_out", dut_vec(), pack(1'b1, 1'b1, 8'h00, 8'h00, 3'b010));
        @(negedge i_Clk);
        chk("hold_out", dut_vec(), pack(1'b1, 1'b0, 8'h00, 8'h00, 3'b010));

        iter_case("mul_5x3", OP_MUL, 8'h05, 8'h03, 8'h0F, 8'h00, 3'b000);
        iter_case("mul_ffxff", OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 3'b001);
        iter_case("div_5_3", OP_DIV, 8'h05, 8'h03, 8'h01, 8'h02, 3'b000);
        iter_case("div_5_0", OP_DIV, 8'h05, 8'h00, 8'hFF, 8'h05, 3'b001);

        // a request arriving mid-multiply must be dropped
        drive(OP_MUL, 8'h05, 8'h03);
        @(negedge i_Clk);
        drive(OP_ADD, 8'h7F, 8'h01);
        @(negedge i_Clk); i_Valido = 1'b0;
        pulses = 0; seen = '0;
        repeat (15) begin
            if (o_Valido) begin pulses++; seen = o_Resultado; end
            @(negedge i_Clk);
        end
        chk("busy_ignore_pulses", 32'(pulses), 32'd1);
        chk("busy_ignore_result", 32'(seen), 32'h0F);

        drive(OP_DIV, 8'hF0, 8'h07);
        @(negedge i_Clk); i_Valido = 1'b0;
        repeat (3) @(negedge i_Clk);
        i_Reset = 1'b1;
        @(negedge i_Clk); i_Reset = 1'b0;
        chk("abort_reset_out", dut_vec(), pack(1'b1, 1'b0, 8'h00, 8'h00, 3'b000));
        pulses = 0;
        repeat (12) begin
            if (o_Valido) pulses++;
            @(negedge i_Clk);
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);

        drive(4'h0, 8'hAB, 8'hCD);
        @(negedge i_Clk); i_Valido = 1'b0;
        chk("undef_op_out", dut_vec(), pack(1'b1, 1'b1, 8'h00, 8'h00, 3'b000));

        repeat (3000) begin
            @(negedge i_Clk);
            i_Reset       = ($urandom_range(0, 249) == 0);
            i_Valido      = ($urandom_range(0, 2) != 0);
            i_Control_ALU = 4'($urandom_range(0, 15));
            i_Operandos   = 16'($urandom);
            if ($urandom_range(0, 7) == 0) i_Operandos[W-1:0] = '0;
        end
        @(negedge i_Clk);
        i_Reset = 1'b0; i_Valido = 1'b0;
        repeat (W + 4) @(negedge i_Clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
Parametrised, registered ALU with a valid/ready handshake. It is the successor to the 8-bit combinational ALU in the datapath. Single-cycle ops (add, sub, logic, shift) complete in one clock. Multiply (shift-add) and divide (restoring) are iterative over WIDTH cycles, so the core is never stalled by a wide combinational multiplier.

Parameters:
WIDTH, 8, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
i_Clk  in  1  system clock, rising edge
i_Reset  in  1  synchronous, active-high reset
i_Valido  in  1  request strobe; operation accepted when i_Valido && o_Listo
i_Control_ALU  in  4  opcode, sampled on accept
i_Operandos  in  2*WIDTH  packed operands: A=[2W-1:W], B=[W-1:0], sampled on accept
o_Listo  out  1  high when able to accept a request
o_Valido  out  1  one-cycle pulse: result/flags updated this cycle
o_Resultado  out  WIDTH  result; low product for MUL, quotient for DIV
o_Resultado_Alto  out  WIDTH  high product (MUL), remainder (DIV), 0 otherwise
o_Banderas_Estado  out  3  [2]=C, [1]=Z, [0]=V

Behaviour:
- Reset (synchronous, i_Reset=1 at edge): state=INACTIVO; o_Listo=1; o_Valido=0; o_Resultado, o_Resultado_Alto and o_Banderas_Estado all 0. Aborts any in-flight MUL/DIV and emits no o_Valido.
- Opcodes:
  - 1000 ADD: A+B; C=carry-out; V=signed overflow.
  - 1001 SUB: A-B; C=borrow (A<B unsigned); V=signed overflow.
  - 1010 MUL: unsigned, 2W-bit product.
  - 1011 DIV: unsigned quotient and remainder.
  - 1100 AND, 1101 OR, 1110 XOR.
  - 1111 SHL: A<<B[$clog2(W)-1:0]; C=last bit shifted out.
  - 0010 NOT: ~A.
  - All others: result 0, flags 0, latency 1.
- Z=1 iff o_Resultado==0 (the high half is excluded). Unless stated above, C=0 and V=0.
- States:
  - INACTIVO: o_Listo=1. On accept of a single-cycle op, the result is registered and o_Valido=1 in the next cycle; state stays INACTIVO, so back-to-back accepts are allowed every cycle. On accept of MUL/DIV, go to CALCULO; counter=0; operands latched.
  - CALCULO: o_Listo=0; i_Valido is ignored (no queuing). One shift-add or restoring-subtract step per clock. After WIDTH steps, write the results, pulse o_Valido, and return to INACTIVO. o_Listo is high in the same cycle as o_Valido.
- Latency (accept edge to o_Valido high):
  - Single-cycle ops: 1 clock.
  - MUL/DIV: WIDTH+1 clocks.
  - o_Listo is low for exactly WIDTH cycles.
- MUL flags: V=1 iff the high half is nonzero; C=0.
- DIV by zero: o_Resultado all ones, o_Resultado_Alto=A, V=1; the full WIDTH+1 latency is still taken.
- Outputs hold their last values between o_Valido pulses. There is no output backpressure; the consumer must take the result on the pulse.
- Operand or opcode changes while in CALCULO have no effect on the computation in progress.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD…OP_NOT)
  - flag bit indices (FLG_C=2, FLG_Z=1, FLG_V=0)
  - state enum {INACTIVO, CALCULO}
- One sub-module, alu_iterativa: the MUL/DIV datapath (accumulator, shift register, counter, start/done). The top level holds the FSM and the combinational single-cycle ops.

Test Plan:
1. W=8, ADD, A=0x7F, B=0x01 -> 1 clock later o_Valido=1, o_Resultado=0x80, flags C=0 Z=0 V=1.
2. SUB, A=0xEE, B=0xF7 -> o_Resultado=0xF7, C=1, V=0, Z=0. Then XOR A=0x55, B=0x55 on the next cycle -> 0x00, Z=1, one cycle after the SUB result (back-to-back).
3. MUL, A=0x05, B=0x03 -> o_Listo low 8 cycles; o_Valido 9 clocks after accept; o_Resultado=0x0F, o_Resultado_Alto=0x00, V=0. Repeat with A=0xFF, B=0xFF -> 0x01, high 0xFE, V=1.
4. DIV, A=0x05, B=0x03 -> quotient 0x01, remainder 0x02. DIV with B=0 -> o_Resultado=0xFF, o_Resultado_Alto=0x05, V=1, same 9-clock latency.
5. i_Valido pulsed with ADD during the MUL CALCULO window -> ignored: exactly one o_Valido, carrying the MUL result.
6. i_Reset=1 at iteration 4 of a DIV -> next cycle all outputs 0, o_Listo=1, no o_Valido. Opcode 0x0 -> result 0, flags 0, latency 1.
